// File: rtl/nonce_target_scan_if.sv
// ============================================================================
// Module      : nonce_target_scan_if
// Description : Single-port memory bus shared between the hash core and the
//               nonce target scanner (read-only use by the scanner).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nonce_target_scan_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        output mem_read_data
    );
endinterface

`default_nettype wire

// File: rtl/nonce_target_scan.sv
// ============================================================================
// Module      : nonce_target_scan
// Description : Reads NUM_NONCES hash words from memory, flags each word that
//               is below the target and reports the lowest winning index.
//               Optional min-hash tracking is enabled by SCAN_MIN_TRACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_target_scan #(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = $clog2(NUM_NONCES)
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  start_i,
    input  wire logic [15:0]           result_addr_i,
    input  wire logic [31:0]           target_i,
    output logic                       done_o,
    output logic                       found_o,
    output logic [IDX_W-1:0]           nonce_idx_o,
    output logic [NUM_NONCES-1:0]      hit_mask_o,
`ifdef SCAN_MIN_TRACK_EN
    output logic [31:0]                min_hash_o,
    output logic [IDX_W-1:0]           min_idx_o,
`endif
    nonce_target_scan_if.master        mem
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] c_num = CNT_W'(NUM_NONCES);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q,  state_d;
    logic [31:0]             tgt_q,    tgt_d;
    logic [15:0]             addr_q,   addr_d;
    logic [CNT_W-1:0]        issue_q,  issue_d;
    logic [CNT_W-1:0]        cap_q,    cap_d;
    logic [NUM_NONCES-1:0]   mask_q,   mask_d;
    logic                    found_q,  found_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic                    done_q,   done_d;
`ifdef SCAN_MIN_TRACK_EN
    logic [31:0]             run_min_q,     run_min_d;
    logic [IDX_W-1:0]        run_min_idx_q, run_min_idx_d;
    logic [31:0]             min_hash_q,    min_hash_d;
    logic [IDX_W-1:0]        min_idx_q,     min_idx_d;
`endif

    logic                    w_hit;
    logic                    w_cap_en;
    logic [IDX_W-1:0]        w_first_idx;

    assign w_hit    = mem.mem_read_data < tgt_q;
    // The first FETCH edge only launches the second address; data lags by two edges.
    assign w_cap_en = ((state_q == S_FETCH) && (issue_q != c_one)) || (state_q == S_DRAIN);

    always_comb begin
        w_first_idx = '0;
        for (int i = NUM_NONCES - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                w_first_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        issue_d = issue_q;
        cap_d   = cap_q;
        mask_d  = mask_q;
        found_d = found_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef SCAN_MIN_TRACK_EN
        run_min_d     = run_min_q;
        run_min_idx_d = run_min_idx_q;
        min_hash_d    = min_hash_q;
        min_idx_d     = min_idx_q;
`endif

        if (w_cap_en) begin
            mask_d[cap_q[IDX_W-1:0]] = w_hit;
            cap_d                    = cap_q + c_one;
`ifdef SCAN_MIN_TRACK_EN
            if (mem.mem_read_data < run_min_q) begin
                run_min_d     = mem.mem_read_data;
                run_min_idx_d = cap_q[IDX_W-1:0];
            end
`endif
        end

        case (state_q)
            S_IDLE: begin
                // The cycle carrying the done pulse still belongs to DONE.
                if (start_i && !done_q) begin
                    tgt_d   = target_i;
                    addr_d  = result_addr_i;
                    issue_d = c_one;
                    cap_d   = '0;
                    mask_d  = '0;
                    found_d = 1'b0;
                    idx_d   = '0;
`ifdef SCAN_MIN_TRACK_EN
                    run_min_d     = 32'hFFFF_FFFF;
                    run_min_idx_d = '0;
`endif
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue_q < c_num) begin
                    addr_d  = addr_q + 16'd1;
                    issue_d = issue_q + c_one;
                end
                if (issue_d == c_num) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap_d == c_num) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                found_d = |mask_q;
                idx_d   = w_first_idx;
                done_d  = 1'b1;
`ifdef SCAN_MIN_TRACK_EN
                min_hash_d = run_min_q;
                min_idx_d  = run_min_idx_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            addr_q  <= '0;
            issue_q <= '0;
            cap_q   <= '0;
            mask_q  <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef SCAN_MIN_TRACK_EN
            run_min_q     <= '0;
            run_min_idx_q <= '0;
            min_hash_q    <= '0;
            min_idx_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            issue_q <= issue_d;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            found_q <= found_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef SCAN_MIN_TRACK_EN
            run_min_q     <= run_min_d;
            run_min_idx_q <= run_min_idx_d;
            min_hash_q    <= min_hash_d;
            min_idx_q     <= min_idx_d;
`endif
        end
    end

    assign done_o      = done_q;
    assign found_o     = found_q;
    assign nonce_idx_o = idx_q;
    assign hit_mask_o  = mask_q;
`ifdef SCAN_MIN_TRACK_EN
    assign min_hash_o  = min_hash_q;
    assign min_idx_o   = min_idx_q;
`endif

    assign mem.mem_clk  = clk;
    assign mem.mem_we   = 1'b0;
    assign mem.mem_addr = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_nonce_target_scan.sv
// ============================================================================
// Module      : tb_nonce_target_scan
// Description : Self-checking bench for nonce_target_scan: directed vector
//               table, corner-case sequences and randomized scans vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonce_target_scan;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [15:0]   result_addr;
    logic [31:0]   target;
    logic          done;
    logic          found;
    logic [IW-1:0] nonce_idx;
    logic [N-1:0]  hit_mask;
`ifdef SCAN_MIN_TRACK_EN
    logic [31:0]   min_hash;
    logic [IW-1:0] min_idx;
`endif

    nonce_target_scan_if bus ();

    nonce_target_scan #(.NUM_NONCES(N)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_i       (start),
        .result_addr_i (result_addr),
        .target_i      (target),
        .done_o        (done),
        .found_o       (found),
        .nonce_idx_o   (nonce_idx),
        .hit_mask_o    (hit_mask),
`ifdef SCAN_MIN_TRACK_EN
        .min_hash_o    (min_hash),
        .min_idx_o     (min_idx),
`endif
        .mem           (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: address registered on one edge, data visible for the next.
    logic [31:0] ram [0:65535];
    always @(posedge bus.mem_clk) begin
        bus.mem_read_data <= ram[bus.mem_addr];
    end

    int          total = 0;
    int          bad   = 0;
    logic [15:0] addr_log [0:63];

    typedef struct {
        int            pat;
        logic [15:0]   base;
        logic [31:0]   tgt;
        logic [N-1:0]  mask;
        logic          found;
        logic [IW-1:0] idx;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fill(input int pat, input logic [15:0] base);
        for (int i = 0; i < N; i++) begin
            logic [31:0] w;
            case (pat)
                0:       w = 32'h1000_0000 * (i + 1);
                1:       w = (i == 9) ? 32'h0000_0042 : 32'hFFFF_FFFF;
                default: w = (i == 5) ? 32'h0000_0500 : 32'h0000_0600 + i;
            endcase
            ram[16'(base + i)] = w;
        end
    endtask

    task automatic model(input logic [15:0] base, input logic [31:0] tgt,
                         output logic [N-1:0] m, output logic f, output logic [IW-1:0] idx,
                         output logic [31:0] mn, output logic [IW-1:0] mi);
        m = '0; f = 1'b0; idx = '0; mn = 32'hFFFF_FFFF; mi = '0;
        for (int i = 0; i < N; i++) begin
            logic [31:0] w;
            w = ram[16'(base + i)];
            if (w < tgt) begin
                m[i] = 1'b1;
                if (!f) begin
                    f   = 1'b1;
                    idx = IW'(i);
                end
            end
            if (w < mn) begin
                mn = w;
                mi = IW'(i);
            end
        end
    endtask

    task automatic wait_done(input logic [15:0] base, input logic [31:0] tgt, input int chg,
                             output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == chg) begin
                start       = 1'b1;
                target      = ~tgt;
                result_addr = base ^ 16'h5555;
            end else if (k == chg + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            addr_log[k] = bus.mem_addr;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_scan(input logic [15:0] base, input logic [31:0] tgt, input int chg,
                            output int lat);
        @(negedge clk);
        start       = 1'b1;
        result_addr = base;
        target      = tgt;
        @(negedge clk);
        start       = 1'b0;
        addr_log[0] = bus.mem_addr;
        wait_done(base, tgt, chg, lat);
    endtask

    task automatic verify(input string tag, input logic [15:0] base, input logic [31:0] tgt,
                          input int lat, input logic [N-1:0] emask, input logic efound,
                          input logic [IW-1:0] eidx);
        logic [N-1:0]  mm;
        logic          mf;
        logic [IW-1:0] mx, mi;
        logic [31:0]   mn;
        model(base, tgt, mm, mf, mx, mn, mi);
        check($sformatf("%s latency", tag), lat, N + 2);
        check($sformatf("%s hit_mask", tag), hit_mask, emask);
        check($sformatf("%s found", tag), found, efound);
        check($sformatf("%s nonce_idx", tag), nonce_idx, eidx);
`ifdef SCAN_MIN_TRACK_EN
        check($sformatf("%s min_hash", tag), min_hash, mn);
        check($sformatf("%s min_idx", tag), min_idx, mi);
`endif
        @(negedge clk);
        check($sformatf("%s done_pulse", tag), done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int quiet;

        // Word 15 of pattern 0 wraps to zero, so it is below any nonzero target.
        vecs[0] = '{0, 16'h0100, 32'h3000_0000, 16'h8003, 1'b1, 4'd0};
        vecs[1] = '{1, 16'h0200, 32'h0000_0100, 16'h0200, 1'b1, 4'd9};
        vecs[2] = '{2, 16'h0300, 32'h0000_0500, 16'h0000, 1'b0, 4'd0};
        vecs[3] = '{2, 16'h0300, 32'h0000_0000, 16'h0000, 1'b0, 4'd0};
        vecs[4] = '{0, 16'h0400, 32'h0000_0001, 16'h8000, 1'b1, 4'd15};
        vecs[5] = '{0, 16'h0500, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 4'd0};
        vecs[6] = '{2, 16'h0600, 32'h0000_0501, 16'h0020, 1'b1, 4'd5};

        reset_n = 1'b0; start = 1'b0; result_addr = '0; target = '0;
        repeat (3) @(negedge clk);
        check("reset done", done, 1'b0);
        check("reset found", found, 1'b0);
        check("reset nonce_idx", nonce_idx, '0);
        check("reset hit_mask", hit_mask, '0);
        check("reset mem_addr", bus.mem_addr, '0);
        check("reset mem_we", bus.mem_we, 1'b0);
`ifdef SCAN_MIN_TRACK_EN
        check("reset min_hash", min_hash, '0);
        check("reset min_idx", min_idx, '0);
`endif
        reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].pat, vecs[v].base);
            run_scan(vecs[v].base, vecs[v].tgt, -1, lat);
            verify($sformatf("vec%0d", v), vecs[v].base, vecs[v].tgt, lat,
                   vecs[v].mask, vecs[v].found, vecs[v].idx);
        end

        // Address wrap, plus a start pulse and target change while busy.
        fill(0, 16'hFFFE);
        run_scan(16'hFFFE, 32'h3000_0000, 3, lat);
        for (int k = 0; k < N; k++) begin
            check($sformatf("wrap addr%0d", k), addr_log[k], 16'(16'hFFFE + k));
        end
        check("wrap mem_we", bus.mem_we, 1'b0);
        verify("wrap", 16'hFFFE, 32'h3000_0000, lat, 16'h8003, 1'b1, 4'd0);

        // Reset in the middle of a scan.
        @(negedge clk);
        start = 1'b1; result_addr = 16'h0100; target = 32'h3000_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort hit_mask", hit_mask, '0);
        check("abort mem_addr", bus.mem_addr, '0);
        check("abort done", done, 1'b0);
        check("abort found", found, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        quiet = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) quiet++;
        end
        check("abort no_done", quiet, 0);
        run_scan(16'hFFFE, 32'h3000_0000, -1, lat);
        verify("restart", 16'hFFFE, 32'h3000_0000, lat, 16'h8003, 1'b1, 4'd0);

        // Back-to-back: start raised during the done cycle and held one more cycle.
        run_scan(16'h0100, 32'h3000_0000, -1, lat);
        check("b2b first latency", lat, N + 2);
        check("b2b first mask", hit_mask, 16'h8003);
        start = 1'b1; result_addr = 16'h0200; target = 32'h0000_0100;
        @(negedge clk);
        check("b2b reject hold_mask", hit_mask, 16'h8003);
        check("b2b reject done_low", done, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b accept clear", hit_mask, '0);
        check("b2b accept found_clr", found, 1'b0);
        wait_done(16'h0200, 32'h0000_0100, -1, lat);
        verify("b2b second", 16'h0200, 32'h0000_0100, lat, 16'h0200, 1'b1, 4'd9);

        // Randomized scans against the reference model.
        for (int r = 0; r < 10; r++) begin
            logic [15:0]   base;
            logic [31:0]   tgt;
            logic [N-1:0]  mm;
            logic          mf;
            logic [IW-1:0] mx, mi;
            logic [31:0]   mn;
            base = 16'($urandom);
            tgt  = $urandom >> $urandom_range(0, 6);
            for (int i = 0; i < N; i++) begin
                ram[16'(base + i)] = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h00FF_FFFF)
                                                                 : $urandom;
            end
            if ($urandom_range(0, 1) == 1) ram[16'(base + $urandom_range(0, N - 1))] = tgt;
            model(base, tgt, mm, mf, mx, mn, mi);
            run_scan(base, tgt, -1, lat);
            verify($sformatf("rand%0d", r), base, tgt, lat, mm, mf, mx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
